// File: rtl/mem_arbiter_pkg.sv
// Shared types and width helpers for the memory-port arbiter; no logic, no latency.
// Backpressure is not applicable here: types only.
package mem_arb_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Pointer and counter widths never collapse to zero bits.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner pick (fixed priority or round-robin from rr_ptr); zero latency.
// No backpressure: output simply tracks req every cycle.
module arb_pick
  import mem_arb_types::*;
#(
  parameter int N  = 2,
  parameter bit RR = 1'b0,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] idx,
  output logic          any
);

  int start_i;
  int pos_i;

  always_comb begin
    gnt_oh  = '0;
    idx     = '0;
    any     = 1'b0;
    start_i = RR ? int'(rr_ptr) : 0;
    pos_i   = 0;
    // Fixed priority is the round-robin search anchored at index 0.
    for (int off = 0; off < N; off++) begin
      pos_i = (start_i + off) % N;
      if (!any && req[pos_i]) begin
        any           = 1'b1;
        gnt_oh[pos_i] = 1'b1;
        idx           = PW'(pos_i);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter for one memory port; grant is combinational, rvalid one cycle after mem_ready.
// Requesters hold until gnt; mem_ready stalls the port, with an optional MAX_WAIT abort that returns err.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int N_CHANNELS  = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_WAIT    = 255
) (
  input  logic                             clk,
  input  logic                             rst_async,
  input  logic [N_CHANNELS-1:0]            req,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_CHANNELS-1:0]            req_we,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] req_wdata,
  output logic [N_CHANNELS-1:0]            gnt,
  output logic [N_CHANNELS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [N_CHANNELS-1:0]            err,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic                             mem_write_en,
  output logic [DATA_WIDTH-1:0]            mem_write_value,
  input  logic [DATA_WIDTH-1:0]            mem_read_value,
  input  logic                             mem_ready
);

  localparam int PW = ptr_w(N_CHANNELS);
  localparam int CW = cnt_w(MAX_WAIT);

  arb_state_t             state, state_nxt;
  logic [PW-1:0]          rr_ptr, rr_nxt, pick_idx;
  logic [N_CHANNELS-1:0]  pick_oh, owner_oh;
  logic                   pick_any;
  logic                   take;
  logic                   timeout;
  logic [CW-1:0]          wait_cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   we_q;
  logic [N_CHANNELS-1:0]  rvalid_q, err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  arb_pick #(
    .N  (N_CHANNELS),
    .RR (ROUND_ROBIN != 0),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign timeout = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT)) && !mem_ready;
  assign rr_nxt  = (pick_idx == PW'(N_CHANNELS - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          take      = 1'b1;
          state_nxt = BUSY;
          // Grant is masked while reset is held so all outputs read zero.
          if (rst_async) gnt = pick_oh;
        end
      end
      BUSY: begin
        if (mem_ready || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      rr_ptr   <= '0;
      owner_oh <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wait_cnt <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      if (take) begin
        owner_oh <= pick_oh;
        addr_q   <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q  <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
        we_q     <= req_we[pick_idx];
        rr_ptr   <= rr_nxt;
      end
      if (state == BUSY) begin
        if (mem_ready) begin
          rvalid_q <= owner_oh;
          rdata_q  <= mem_read_value;
          wait_cnt <= '0;
        end else if (timeout) begin
          rvalid_q <= owner_oh;
          err_q    <= owner_oh;
          rdata_q  <= '0;
          wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  // Address/data registers only load on a grant, so they hold between accesses.
  assign mem_address     = addr_q;
  assign mem_write_value = wdata_q;
  assign mem_write_en    = (state == BUSY) && we_q;
  assign rvalid          = rvalid_q;
  assign err             = err_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (2ch fixed priority, 3ch round-robin with short timeout)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [2:0]    req_v  [2];
  logic [2:0]    we_v   [2];
  logic [AW-1:0] addr_v [2][3];
  logic [DW-1:0] wd_v   [2][3];
  logic [DW-1:0] rdm_v  [2];
  logic          ready_v[2];

  logic [1:0]    gnt_a, rvalid_a, err_a;
  logic [2:0]    gnt_b, rvalid_b, err_b;
  logic [DW-1:0] rdata_a, rdata_b, mwv_a, mwv_b;
  logic [AW-1:0] ma_a, ma_b;
  logic          mwe_a, mwe_b;

  logic [2:0]    gnt_o[2], rv_o[2], err_o[2];
  logic [DW-1:0] rd_o[2], mwv_o[2];
  logic [AW-1:0] ma_o[2];
  logic          mwe_o[2];

  assign gnt_o[0] = {1'b0, gnt_a};    assign gnt_o[1] = gnt_b;
  assign rv_o[0]  = {1'b0, rvalid_a}; assign rv_o[1]  = rvalid_b;
  assign err_o[0] = {1'b0, err_a};    assign err_o[1] = err_b;
  assign rd_o[0]  = rdata_a;          assign rd_o[1]  = rdata_b;
  assign mwv_o[0] = mwv_a;            assign mwv_o[1] = mwv_b;
  assign ma_o[0]  = ma_a;             assign ma_o[1]  = ma_b;
  assign mwe_o[0] = mwe_a;            assign mwe_o[1] = mwe_b;

  mem_arbiter #(.N_CHANNELS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .MAX_WAIT(255)) dut_a (
    .clk(clk), .rst_async(rst), .req(req_v[0][1:0]),
    .req_addr({addr_v[0][1], addr_v[0][0]}), .req_we(we_v[0][1:0]),
    .req_wdata({wd_v[0][1], wd_v[0][0]}), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .err(err_a), .mem_address(ma_a), .mem_write_en(mwe_a), .mem_write_value(mwv_a),
    .mem_read_value(rdm_v[0]), .mem_ready(ready_v[0]));

  mem_arbiter #(.N_CHANNELS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst_async(rst), .req(req_v[1]),
    .req_addr({addr_v[1][2], addr_v[1][1], addr_v[1][0]}), .req_we(we_v[1]),
    .req_wdata({wd_v[1][2], wd_v[1][1], wd_v[1][0]}), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .err(err_b), .mem_address(ma_b), .mem_write_en(mwe_b), .mem_write_value(mwv_b),
    .mem_read_value(rdm_v[1]), .mem_ready(ready_v[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access per port, pick by scan order.
  int            n_ch [2] = '{2, 3};
  int            rr_en[2] = '{0, 1};
  int            maxw [2] = '{255, 4};
  bit            m_busy [2];
  int            m_owner[2];
  int            m_waits[2];
  int            m_rr   [2];
  logic          m_we   [2];
  logic [2:0]    m_rv   [2];
  logic [2:0]    m_err  [2];
  logic [DW-1:0] m_rd   [2];
  logic [DW-1:0] m_wd   [2];
  logic [AW-1:0] m_ad   [2];

  function automatic int pick(input int k, input logic [2:0] r);
    int base;
    base = (rr_en[k] != 0) ? m_rr[k] : 0;
    for (int o = 0; o < n_ch[k]; o++) begin
      if (r[(base + o) % n_ch[k]]) return (base + o) % n_ch[k];
    end
    return -1;
  endfunction

  initial begin
    int w;
    logic [2:0] eg;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          chk($sformatf("rst_gnt%0d", k), gnt_o[k], 0);
          chk($sformatf("rst_rvalid%0d", k), rv_o[k], 0);
          chk($sformatf("rst_err%0d", k), err_o[k], 0);
          chk($sformatf("rst_rdata%0d", k), rd_o[k], 0);
          chk($sformatf("rst_addr%0d", k), ma_o[k], 0);
          chk($sformatf("rst_we%0d", k), mwe_o[k], 0);
          chk($sformatf("rst_wval%0d", k), mwv_o[k], 0);
          m_busy[k] = 0; m_waits[k] = 0; m_rr[k] = 0; m_we[k] = 0;
          m_rv[k] = 0; m_err[k] = 0; m_rd[k] = 0; m_wd[k] = 0; m_ad[k] = 0; m_owner[k] = 0;
        end else begin
          w  = pick(k, req_v[k]);
          eg = (!m_busy[k] && w >= 0) ? 3'(1 << w) : 3'b000;
          chk($sformatf("m_gnt%0d", k), gnt_o[k], eg);
          chk($sformatf("m_rvalid%0d", k), rv_o[k], m_rv[k]);
          chk($sformatf("m_err%0d", k), err_o[k], m_err[k]);
          if (m_rv[k] != 0) chk($sformatf("m_rdata%0d", k), rd_o[k], m_rd[k]);
          chk($sformatf("m_addr%0d", k), ma_o[k], m_ad[k]);
          chk($sformatf("m_wval%0d", k), mwv_o[k], m_wd[k]);
          chk($sformatf("m_we%0d", k), mwe_o[k], m_busy[k] && m_we[k]);
          m_rv[k]  = 0;
          m_err[k] = 0;
          if (m_busy[k]) begin
            if (ready_v[k]) begin
              m_rv[k] = 3'(1 << m_owner[k]); m_rd[k] = rdm_v[k];
              m_busy[k] = 0; m_waits[k] = 0;
            end else if (maxw[k] != 0 && m_waits[k] == maxw[k]) begin
              m_rv[k] = 3'(1 << m_owner[k]); m_err[k] = m_rv[k]; m_rd[k] = 0;
              m_busy[k] = 0; m_waits[k] = 0;
            end else begin
              m_waits[k]++;
            end
          end else if (w >= 0) begin
            m_busy[k] = 1; m_owner[k] = w;
            m_ad[k] = addr_v[k][w]; m_wd[k] = wd_v[k][w]; m_we[k] = we_v[k][w];
            m_rr[k] = (w + 1) % n_ch[k];
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cyc();
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 0; we_v[k] = 0; ready_v[k] = 1'b1;
    end
    repeat (4) cyc();
  endtask

  initial begin
    int g0, g1, wecnt, thr;
    int ord[$];
    int exp_ord[4] = '{0, 1, 2, 0};
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 0; we_v[k] = 0; rdm_v[k] = 0; ready_v[k] = 1'b1;
      for (int i = 0; i < 3; i++) begin addr_v[k][i] = 0; wd_v[k][i] = 0; end
    end
    #3 rst = 1'b0;
    @(negedge clk);
    chk("reset_we_a", mwe_a, 0);
    chk("reset_rvalid_b", rvalid_b, 0);
    cyc(); rst = 1'b1;
    cyc();

    // Single read, zero wait states.
    cyc(); req_v[0] = 3'b001; addr_v[0][0] = 20'h00010; rdm_v[0] = 32'hDEADBEEF;
    @(negedge clk); chk("t1_gnt", gnt_a, 2'b01);
    cyc(); req_v[0] = 0;
    @(negedge clk); chk("t1_addr", ma_a, 20'h00010); chk("t1_gnt_busy", gnt_a, 0);
    cyc(); @(negedge clk); chk("t1_rvalid", rvalid_a, 2'b01); chk("t1_rdata", rdata_a, 32'hDEADBEEF);
    cyc(); @(negedge clk); chk("t1_rvalid_pulse", rvalid_a, 0);

    // Fixed priority starves channel 1.
    g0 = 0; g1 = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(); req_v[0] = 3'b011;
      @(negedge clk); g0 += int'(gnt_a[0]); g1 += int'(gnt_a[1]);
    end
    chk("t2_ch0_grants", g0, 5);
    chk("t2_ch1_grants", g1, 0);
    drain();

    // Round-robin order with wrap.
    for (int c = 0; c < 8; c++) begin
      cyc(); req_v[1] = 3'b111;
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (gnt_b[i]) ord.push_back(i);
    end
    chk("t3_grant_count", ord.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), (ord.size() > i) ? ord[i] : -1, exp_ord[i]);
    drain();

    // Write on channel 1 with three wait states.
    cyc(); req_v[0] = 3'b010; addr_v[0][1] = 20'h0ABCD; we_v[0] = 3'b010;
    wd_v[0][1] = 32'h12345678; ready_v[0] = 1'b0;
    @(negedge clk); chk("t4_gnt", gnt_a, 2'b10);
    wecnt = 0;
    for (int c = 1; c <= 6; c++) begin
      cyc(); req_v[0] = 0; ready_v[0] = (c >= 4);
      @(negedge clk);
      wecnt += int'(mwe_a);
      if (c <= 4) begin
        chk("t4_addr_stable", ma_a, 20'h0ABCD);
        chk("t4_data_stable", mwv_a, 32'h12345678);
      end
      if (c == 5) chk("t4_rvalid", rvalid_a, 2'b10);
    end
    chk("t4_we_cycles", wecnt, 4);
    drain();

    // Timeout on the round-robin instance (MAX_WAIT=4); next request granted on the abort return.
    cyc(); req_v[1] = 3'b001; ready_v[1] = 1'b0; rdm_v[1] = 32'hCAFEF00D;
    @(negedge clk); chk("t5_gnt", gnt_b, 3'b001);
    for (int c = 1; c <= 6; c++) begin
      cyc(); req_v[1] = 3'b010; ready_v[1] = 1'b0;
      @(negedge clk);
      if (c < 6) chk("t5_no_gnt_busy", gnt_b, 0);
      else begin
        chk("t5_rvalid", rvalid_b, 3'b001);
        chk("t5_err", err_b, 3'b001);
        chk("t5_rdata", rdata_b, 0);
        chk("t5_regrant", gnt_b, 3'b010);
      end
    end
    drain();

    // Reset in the middle of a write.
    cyc(); req_v[0] = 3'b001; addr_v[0][0] = 20'h00055; we_v[0] = 3'b001;
    wd_v[0][0] = 32'hA5A5A5A5; ready_v[0] = 1'b0;
    @(negedge clk); chk("t6_gnt", gnt_a, 2'b01);
    cyc(); req_v[0] = 0;
    @(negedge clk); chk("t6_we_busy", mwe_a, 1);
    cyc(); rst = 1'b0; #1; chk("t6_we_drop", mwe_a, 0);
    repeat (2) begin
      cyc(); @(negedge clk); chk("t6_no_rvalid", rvalid_a, 0);
    end
    cyc(); rst = 1'b1; req_v[0] = 3'b001; we_v[0] = 0; ready_v[0] = 1'b1;
    @(negedge clk); chk("t6_after_reset_gnt", gnt_a, 2'b01);
    drain();

    // Random traffic, ready probability stepped high/medium/low, one reset pulse.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      thr = ((c / 500) % 3 == 0) ? 85 : (((c / 500) % 3 == 1) ? 40 : 8);
      for (int k = 0; k < 2; k++) begin
        req_v[k]   = 3'($urandom_range(0, 7));
        we_v[k]    = 3'($urandom);
        rdm_v[k]   = $urandom;
        ready_v[k] = ($urandom_range(0, 99) < thr);
        for (int i = 0; i < 3; i++) begin
          addr_v[k][i] = 20'($urandom);
          wd_v[k][i]   = $urandom;
        end
      end
      if (c == 1500) rst = 1'b0;
      if (c == 1503) rst = 1'b1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised memory-port arbiter for the wramp core and its successors. Replaces the fixed fetch/mem-access address mux with N requesters sharing one memory port. Supports variable-latency memory through a ready handshake, fixed-priority or round-robin arbitration, and a wait-state timeout. Sits between i_fetch, mem_access and any future requesters (DMA, debug) and the external memory bus.

Parameters:
N_CHANNELS, 2, number of requesters; index 0 is the highest fixed priority (≥1).
ADDR_WIDTH, 20, memory address width.
DATA_WIDTH, 32, memory data width.
ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin.
MAX_WAIT, 255, wait cycles before abort; 0 disables the timeout.

Ports:
clk  in  1  clock; one clock domain.
rst_async  in  1  reset; asynchronous, active-low.
req  in  N_CHANNELS  per-channel request.
req_addr  in  N_CHANNELS*ADDR_WIDTH  flattened; channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
req_we  in  N_CHANNELS  per-channel write enable.
req_wdata  in  N_CHANNELS*DATA_WIDTH  flattened write data.
gnt  out  N_CHANNELS  one-hot; request accepted this cycle.
rvalid  out  N_CHANNELS  one-hot pulse; access complete.
rdata  out  DATA_WIDTH  read data; valid while rvalid is set.
err  out  N_CHANNELS  pulses together with rvalid on timeout.
mem_address  out  ADDR_WIDTH  memory address.
mem_write_en  out  1  memory write strobe.
mem_write_value  out  DATA_WIDTH  memory write data.
mem_read_value  in  DATA_WIDTH  memory read data.
mem_ready  in  1  memory has completed the access this cycle.

Behaviour:
- Reset (rst_async low, asynchronous): state IDLE; rr_ptr=0; wait_cnt=0. All outputs are 0: gnt, rvalid, rdata, err, mem_address, mem_write_en, mem_write_value.
- Reset mid-access: the access is abandoned, mem_write_en drops immediately, and no rvalid is issued.
- States: IDLE, BUSY.
- IDLE:
  - If any req bit is set, gnt[winner]=1 combinationally in the same cycle.
  - At the clock edge, latch owner, addr, we and wdata of the winner; go to BUSY.
  - If no req is set, stay in IDLE.
- Winner selection:
  - ROUND_ROBIN=0: lowest set index wins.
  - ROUND_ROBIN=1: first set index searching upward from rr_ptr, wrapping modulo N_CHANNELS.
  - On each grant, rr_ptr ← (winner+1) mod N_CHANNELS.
- BUSY:
  - Drive mem_address, mem_write_value and mem_write_en (=latched we) from the latched values; hold them stable until exit.
  - gnt=0 throughout.
  - If mem_ready=1: next cycle rvalid[owner]=1 for exactly one cycle; rdata = mem_read_value sampled at that edge (writes also return the sampled value; requesters ignore it). Return to IDLE.
  - If mem_ready=0: wait_cnt increments.
  - If MAX_WAIT≠0 and wait_cnt==MAX_WAIT with mem_ready=0: abort. Next cycle rvalid[owner]=1, err[owner]=1, rdata=0. Return to IDLE. wait_cnt clears on every BUSY exit.
- Outside BUSY, mem_write_en=0 and mem_address and mem_write_value hold their last values.
- Latency: req in cycle 0 with mem_ready in cycle 1 gives rvalid in cycle 2. Each wait state adds 1 cycle.
- Throughput: at most one access per 2 cycles. The rvalid cycle is also an IDLE cycle, so a new grant may occur in the same cycle as rvalid.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt.
  - Dropping req before gnt withdraws the request.
  - req during BUSY is ignored; no gnt is given and the request remains pending.
- N_CHANNELS=1: no arbitration; rr_ptr is constant 0.
- Width rules: wait_cnt is $clog2(MAX_WAIT+1) bits and saturates (cannot wrap). rr_ptr is $clog2(N_CHANNELS) bits, minimum 1.

Decomposition:
- Package mem_arb_types: state enum (IDLE, BUSY).
- Sub-module arb_pick: combinational winner selection from req, rr_ptr and ROUND_ROBIN. Outputs a one-hot grant plus a binary index.

Test Plan:
- Reset then req=01, addr0=0x00010, we=0, mem_ready=1 from cycle 1, mem_read_value=0xDEADBEEF -> gnt=01 in cycle 0, mem_address=0x00010 in cycle 1, rvalid=01 and rdata=0xDEADBEEF in cycle 2.
- ROUND_ROBIN=0, req=11 held continuously -> every grant goes to channel 0; channel 1 is never granted while req[0] stays high.
- ROUND_ROBIN=1, N_CHANNELS=3, req=111 held -> grant order 0,1,2,0; rr_ptr wraps from 2 to 0.
- Write, ch1 addr=0x0ABCD, wdata=0x12345678, mem_ready low for 3 cycles -> mem_write_en high for 4 cycles with address and data stable; rvalid=10 on cycle 5.
- MAX_WAIT=4, mem_ready held low -> after 4 wait cycles rvalid[owner]=1, err[owner]=1, rdata=0; FSM returns to IDLE and next request is granted.
- Assert rst_async low mid-BUSY during a write -> mem_write_en=0 immediately; no rvalid; after release, req=01 is granted normally.
